hazard_ctrl: RTL and testbench

//  Hazard tracker/stall controller for the 5-stage MIPS pipeline, fed directly by the decoder's D-stage outputs.
//  Per-stage inputs: write address, Regwrite, TNew_D, TUse_D1/TUse_D2.

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - D-stage decode fields in, stall/flush/forward controls out
//
// Signals
//   A1_D, A2_D, A3_D   source/destination register addresses of the D instruction
//   Regwrite_D         D instruction writes the register file
//   TNew_D             cycles until the D instruction's result exists
//   TUse_D1, TUse_D2   cycles until rs/rt are needed (10 = not used)
//   stall, flush_E     freeze F/D and bubble D/E
//   fwd_rs_D, fwd_rt_D D-stage sources: 0 GRF, 1 W, 2 M, 3 E
//   fwd_rs_E, fwd_rt_E E-stage sources: 0 regfile value, 1 W, 2 M
//   fwd_rt_M           M-stage store data taken from W
// Modports
//   master  decoder/pipeline side (drives decode fields)
//   slave   hazard controller side (drives controls)

interface hazard_ctrl_if #(
    parameter int RA_W = 5,
    parameter int T_W  = 8
) ();
    logic [RA_W-1:0] A1_D;
    logic [RA_W-1:0] A2_D;
    logic [RA_W-1:0] A3_D;
    logic            Regwrite_D;
    logic [T_W-1:0]  TNew_D;
    logic [T_W-1:0]  TUse_D1;
    logic [T_W-1:0]  TUse_D2;
    logic            stall;
    logic            flush_E;
    logic [1:0]      fwd_rs_D;
    logic [1:0]      fwd_rt_D;
    logic [1:0]      fwd_rs_E;
    logic [1:0]      fwd_rt_E;
    logic            fwd_rt_M;

    modport master (
        output A1_D, A2_D, A3_D, Regwrite_D, TNew_D, TUse_D1, TUse_D2,
        input  stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );

    modport slave (
        input  A1_D, A2_D, A3_D, Regwrite_D, TNew_D, TUse_D1, TUse_D2,
        output stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard tracker and stall/forward controller for a 5-stage MIPS pipeline
//
// Ports
//   clk    pipeline clock, rising edge
//   reset  asynchronous, active-low; clears all tracking state
//   hz     hazard_ctrl_if.slave: D-stage decode fields in, stall/flush/forward selects out
//
// Each in-flight writer in E/M/W carries its destination, write enable and a
// Tnew countdown that saturates at zero. Stall and forwarding decisions are
// purely combinational from these registers and the current D-stage inputs.

module hazard_ctrl #(
    parameter int RA_W = 5,
    parameter int T_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_ctrl_if.slave         hz
);

    localparam logic [T_W-1:0] T_ONE = {{(T_W-1){1'b0}}, 1'b1};

    // E stage
    logic [RA_W-1:0] a1_e, a2_e, a3_e;
    logic            we_e;
    logic [T_W-1:0]  tnew_e;
    // M stage (A1 is not needed past E)
    logic [RA_W-1:0] a2_m, a3_m;
    logic            we_m;
    logic [T_W-1:0]  tnew_m;
    // W stage
    logic [RA_W-1:0] a3_w;
    logic            we_w;
    logic [T_W-1:0]  tnew_w;

    function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - T_ONE;
    endfunction

    // Producer in some stage still needs more cycles than the consumer can wait.
    function automatic logic stall_hit(
        input logic [RA_W-1:0] a,
        input logic [T_W-1:0]  tuse,
        input logic [RA_W-1:0] a3,
        input logic            we,
        input logic [T_W-1:0]  tnew
    );
        return (a != '0) && we && (a3 == a) && (tnew > tuse);
    endfunction

    // Producer in some stage already holds the final value for this address.
    function automatic logic fwd_hit(
        input logic [RA_W-1:0] a,
        input logic [RA_W-1:0] a3,
        input logic            we,
        input logic [T_W-1:0]  tnew
    );
        return (a != '0) && we && (a3 == a) && (tnew == '0);
    endfunction

    // Nearest ready producer wins: E, then M, then W.
    function automatic logic [1:0] sel_d(input logic [RA_W-1:0] a);
        if (fwd_hit(a, a3_e, we_e, tnew_e)) return 2'd3;
        if (fwd_hit(a, a3_m, we_m, tnew_m)) return 2'd2;
        if (fwd_hit(a, a3_w, we_w, tnew_w)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [RA_W-1:0] a);
        if (fwd_hit(a, a3_m, we_m, tnew_m)) return 2'd2;
        if (fwd_hit(a, a3_w, we_w, tnew_w)) return 2'd1;
        return 2'd0;
    endfunction

    logic stall_int;

    assign stall_int = stall_hit(hz.A1_D, hz.TUse_D1, a3_e, we_e, tnew_e)
                     | stall_hit(hz.A1_D, hz.TUse_D1, a3_m, we_m, tnew_m)
                     | stall_hit(hz.A2_D, hz.TUse_D2, a3_e, we_e, tnew_e)
                     | stall_hit(hz.A2_D, hz.TUse_D2, a3_m, we_m, tnew_m);

    assign hz.stall    = stall_int;
    assign hz.flush_E  = stall_int;
    assign hz.fwd_rs_D = sel_d(hz.A1_D);
    assign hz.fwd_rt_D = sel_d(hz.A2_D);
    assign hz.fwd_rs_E = sel_e(a1_e);
    assign hz.fwd_rt_E = sel_e(a2_e);
    assign hz.fwd_rt_M = we_w && (a3_w == a2_m) && (a2_m != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1_e   <= '0;
            a2_e   <= '0;
            a3_e   <= '0;
            we_e   <= 1'b0;
            tnew_e <= '0;
            a2_m   <= '0;
            a3_m   <= '0;
            we_m   <= 1'b0;
            tnew_m <= '0;
            a3_w   <= '0;
            we_w   <= 1'b0;
            tnew_w <= '0;
        end else begin
            // A stalled decode leaves a bubble in E instead of the held instruction.
            if (stall_int) begin
                a1_e   <= '0;
                a2_e   <= '0;
                a3_e   <= '0;
                we_e   <= 1'b0;
                tnew_e <= '0;
            end else begin
                a1_e   <= hz.A1_D;
                a2_e   <= hz.A2_D;
                a3_e   <= hz.A3_D;
                we_e   <= hz.Regwrite_D;
                tnew_e <= dec_sat(hz.TNew_D);
            end
            a2_m   <= a2_e;
            a3_m   <= a3_e;
            we_m   <= we_e;
            tnew_m <= dec_sat(tnew_e);
            a3_w   <= a3_m;
            we_w   <= we_m;
            tnew_w <= dec_sat(tnew_m);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;
    localparam int RA_W = 5;
    localparam int T_W  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_ctrl_if #(.RA_W(RA_W), .T_W(T_W)) hif ();

    hazard_ctrl #(.RA_W(RA_W), .T_W(T_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    // Reference: list of in-flight instructions, index 0 = E, 1 = M, 2 = W.
    // Each keeps the Tnew it had at decode; its current Tnew is derived from age.
    typedef struct {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic       we;
        int         tnew_d;
    } instr_t;

    instr_t pipe [3];

    function automatic instr_t bubble();
        instr_t z;
        z.a1 = '0; z.a2 = '0; z.a3 = '0; z.we = 1'b0; z.tnew_d = 0;
        return z;
    endfunction

    function automatic int tnew_at(int k);
        int t;
        t = pipe[k].tnew_d - (k + 1);
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic m_stall();
        for (int k = 0; k < 2; k++) begin
            if (pipe[k].we && pipe[k].a3 != 0) begin
                if (hif.A1_D == pipe[k].a3 && tnew_at(k) > int'(hif.TUse_D1)) return 1'b1;
                if (hif.A2_D == pipe[k].a3 && tnew_at(k) > int'(hif.TUse_D2)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_fwd_d(logic [4:0] a);
        if (a == 0) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (pipe[k].we && pipe[k].a3 == a && tnew_at(k) == 0) return 2'(3 - k);
        return 2'd0;
    endfunction

    function automatic logic [1:0] m_fwd_e(logic [4:0] a);
        if (a == 0) return 2'd0;
        for (int k = 1; k < 3; k++)
            if (pipe[k].we && pipe[k].a3 == a && tnew_at(k) == 0) return 2'(3 - k);
        return 2'd0;
    endfunction

    function automatic logic m_fwd_m();
        return pipe[2].we && pipe[2].a3 == pipe[1].a2 && pipe[1].a2 != 0;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = bubble();
    endtask

    task automatic drive(input int a1, input int a2, input int a3, input int we,
                         input int tnew, input int tu1, input int tu2);
        hif.A1_D       = 5'(a1);
        hif.A2_D       = 5'(a2);
        hif.A3_D       = 5'(a3);
        hif.Regwrite_D = 1'(we);
        hif.TNew_D     = 8'(tnew);
        hif.TUse_D1    = 8'(tu1);
        hif.TUse_D2    = 8'(tu2);
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 10, 10);
    endtask

    // Advance one clock: model captures D (or a bubble) exactly as decided before the edge.
    task automatic tick();
        instr_t d;
        if (m_stall()) d = bubble();
        else begin
            d.a1 = hif.A1_D; d.a2 = hif.A2_D; d.a3 = hif.A3_D;
            d.we = hif.Regwrite_D; d.tnew_d = int'(hif.TNew_D);
        end
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = d;
        if (!reset) clear_model();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_model();
        drive(1, 2, 3, 1, 2, 0, 0);
        n_tests++;
        if ({hif.stall, hif.flush_E, hif.fwd_rs_D, hif.fwd_rt_D, hif.fwd_rs_E, hif.fwd_rt_E, hif.fwd_rt_M} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {hif.stall, hif.flush_E, hif.fwd_rs_D, hif.fwd_rt_D, hif.fwd_rs_E, hif.fwd_rt_E, hif.fwd_rt_M});
        end
        @(negedge clk);
        reset = 1'b1;
        idle();
    endtask

    task automatic test_alu_use();
        drive(0, 0, 1, 1, 2, 10, 10);       // add $1
        tick();
        drive(1, 0, 0, 0, 0, 0, 10);        // beq rs=$1
        n_tests++;
        if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL alu_stall: got %0b want 1", hif.stall); end
        n_tests++;
        if (hif.flush_E !== 1'b1) begin n_fail++; $display("FAIL alu_flush: got %0b want 1", hif.flush_E); end
        tick();
        n_tests++;
        if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL alu_release: got %0b want 0", hif.stall); end
        n_tests++;
        if (hif.fwd_rs_D !== 2'd2) begin n_fail++; $display("FAIL alu_fwd_m: got %0d want 2", hif.fwd_rs_D); end
        tick();
        idle(); tick(); idle(); tick();
    endtask

    task automatic test_load_use();
        drive(0, 0, 2, 1, 3, 10, 10);       // lw $2
        tick();
        drive(0, 2, 0, 0, 0, 10, 0);        // branch reading rt=$2 immediately
        n_tests++;
        if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_e: got %0b want 1", hif.stall); end
        tick();
        n_tests++;
        if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_m: got %0b want 1", hif.stall); end
        tick();
        n_tests++;
        if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL load_release: got %0b want 0", hif.stall); end
        n_tests++;
        if (hif.fwd_rt_D !== 2'd1) begin n_fail++; $display("FAIL load_fwd_w: got %0d want 1", hif.fwd_rt_D); end
        tick();
        idle(); tick(); idle(); tick(); idle(); tick();
    endtask

    task automatic test_jal_jr();
        drive(0, 0, 31, 1, 0, 10, 10);      // jal
        tick();
        drive(31, 0, 0, 0, 0, 0, 10);       // jr $31
        n_tests++;
        if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL jr_stall: got %0b want 0", hif.stall); end
        n_tests++;
        if (hif.fwd_rs_D !== 2'd3) begin n_fail++; $display("FAIL jr_fwd_e: got %0d want 3", hif.fwd_rs_D); end
        tick();
        idle(); tick(); idle(); tick(); idle(); tick();
    endtask

    task automatic test_nearest_and_zero();
        drive(0, 0, 5, 1, 1, 10, 10);
        tick();
        drive(0, 0, 5, 1, 1, 10, 10);
        tick();
        drive(5, 5, 0, 0, 0, 1, 1);
        n_tests++;
        if (hif.fwd_rs_D !== 2'd3 || hif.fwd_rt_D !== 2'd3) begin
            n_fail++; $display("FAIL nearest_d: got %0d/%0d want 3/3", hif.fwd_rs_D, hif.fwd_rt_D);
        end
        tick();
        idle();
        n_tests++;
        if (hif.fwd_rs_E !== 2'd2 || hif.fwd_rt_E !== 2'd2) begin
            n_fail++; $display("FAIL nearest_e: got %0d/%0d want 2/2", hif.fwd_rs_E, hif.fwd_rt_E);
        end
        drive(0, 0, 0, 1, 2, 10, 10);       // write to $0, late result
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (hif.stall !== 1'b0 || hif.fwd_rs_D !== 2'd0) begin
            n_fail++; $display("FAIL zero_reg: got stall %0b fwd %0d want 0/0", hif.stall, hif.fwd_rs_D);
        end
        tick();
        idle(); tick(); idle(); tick(); idle(); tick();
    endtask

    task automatic test_store_fwd();
        drive(0, 0, 3, 1, 3, 10, 10);       // lw $3
        tick();
        drive(0, 3, 0, 0, 0, 10, 2);        // sw rt=$3
        n_tests++;
        if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %0b want 0", hif.stall); end
        tick();
        idle();
        n_tests++;
        if (hif.fwd_rt_E !== 2'd0) begin n_fail++; $display("FAIL sw_not_ready: got %0d want 0", hif.fwd_rt_E); end
        tick();
        n_tests++;
        if (hif.fwd_rt_M !== 1'b1) begin n_fail++; $display("FAIL sw_fwd_m: got %0b want 1", hif.fwd_rt_M); end
        tick(); idle(); tick();
    endtask

    task automatic test_reset_mid_stall();
        drive(0, 0, 1, 1, 2, 10, 10);
        tick();
        drive(1, 0, 0, 0, 0, 0, 10);
        n_tests++;
        if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %0b want 1", hif.stall); end
        reset = 1'b0;
        clear_model();
        #1;
        n_tests++;
        if (hif.stall !== 1'b0 || hif.flush_E !== 1'b0 || hif.fwd_rs_D !== 2'd0) begin
            n_fail++; $display("FAIL rst_drop: got stall %0b flush %0b fwd %0d want 0", hif.stall, hif.flush_E, hif.fwd_rs_D);
        end
        idle(); tick(); tick();
        n_tests++;
        if ({hif.stall, hif.fwd_rs_D, hif.fwd_rs_E, hif.fwd_rt_M} !== 6'd0) begin
            n_fail++; $display("FAIL rst_hold: got %b want 0", {hif.stall, hif.fwd_rs_D, hif.fwd_rs_E, hif.fwd_rt_M});
        end
        @(negedge clk);
        reset = 1'b1;
        idle();
    endtask

    task automatic test_random();
        int tuse_tbl [4];
        tuse_tbl[0] = 0; tuse_tbl[1] = 1; tuse_tbl[2] = 2; tuse_tbl[3] = 10;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  tuse_tbl[$urandom_range(0, 3)], tuse_tbl[$urandom_range(0, 3)]);
            n_tests++;
            if (hif.stall !== m_stall() || hif.flush_E !== m_stall()) begin
                n_fail++; $display("FAIL rnd_stall[%0d]: got %0b/%0b want %0b", i, hif.stall, hif.flush_E, m_stall());
            end
            n_tests++;
            if (hif.fwd_rs_D !== m_fwd_d(hif.A1_D) || hif.fwd_rt_D !== m_fwd_d(hif.A2_D)) begin
                n_fail++; $display("FAIL rnd_fwd_d[%0d]: got %0d/%0d want %0d/%0d", i, hif.fwd_rs_D, hif.fwd_rt_D, m_fwd_d(hif.A1_D), m_fwd_d(hif.A2_D));
            end
            n_tests++;
            if (hif.fwd_rs_E !== m_fwd_e(pipe[0].a1) || hif.fwd_rt_E !== m_fwd_e(pipe[0].a2)) begin
                n_fail++; $display("FAIL rnd_fwd_e[%0d]: got %0d/%0d want %0d/%0d", i, hif.fwd_rs_E, hif.fwd_rt_E, m_fwd_e(pipe[0].a1), m_fwd_e(pipe[0].a2));
            end
            n_tests++;
            if (hif.fwd_rt_M !== m_fwd_m()) begin
                n_fail++; $display("FAIL rnd_fwd_m[%0d]: got %0b want %0b", i, hif.fwd_rt_M, m_fwd_m());
            end
            tick();
        end
    endtask

    initial begin
        clear_model();
        idle();
        test_reset();
        test_alu_use();
        test_load_use();
        test_jal_jr();
        test_nearest_and_zero();
        test_store_fwd();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
